// File: rtl/upc_checkout_scanner.sv
// rtl/upc_checkout_scanner.sv - checkout item scanner with discount/theft classification, counters and alarm
module upc_checkout_scanner #(
    parameter int                          CODE_W      = 3,
    parameter logic [(1 << CODE_W) - 1:0]  DISC_TABLE  = 8'b1110_1100,
    parameter logic [(1 << CODE_W) - 1:0]  EXP_TABLE   = 8'b0011_0001,
    parameter int                          CNT_W       = 4,
    parameter bit                          ALARM_LATCH = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_valid,
    output logic              scan_ready,
    input  logic [CODE_W-1:0] scan_code,
    input  logic              scan_mark,
    input  logic              clear_alarm,
    input  logic              clear_counts,
    output logic              res_valid,
    output logic              res_discounted,
    output logic              res_stolen,
    output logic              alarm,
    output logic [CNT_W-1:0]  item_cnt,
    output logic [CNT_W-1:0]  disc_cnt,
    output logic [CNT_W-1:0]  stolen_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state, state_d;
    logic [CODE_W-1:0]   code_q;
    logic                mark_q;
    logic                hit_disc, hit_stolen;

    logic                res_valid_d, res_disc_d, res_stolen_d, alarm_d;
    logic [CNT_W-1:0]    item_d, disc_d, stolen_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != CNT_MAX) ? c + CNT_ONE : c;
    endfunction

    assign hit_disc   = DISC_TABLE[code_q];
    assign hit_stolen = EXP_TABLE[code_q] & ~mark_q;

    // Held low while in reset so the upstream never sees a ready it cannot use.
    assign scan_ready = reset_n && (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (scan_valid) state_d = EVAL;
            EVAL:    state_d = (hit_stolen && ALARM_LATCH) ? ALARM : IDLE;
            ALARM:   if (clear_alarm) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_valid_d  = (state == EVAL);
        res_disc_d   = res_discounted;
        res_stolen_d = res_stolen;
        alarm_d      = 1'b0;
        item_d       = item_cnt;
        disc_d       = disc_cnt;
        stolen_d     = stolen_cnt;
        case (state)
            EVAL: begin
                res_disc_d   = hit_disc;
                res_stolen_d = hit_stolen;
                alarm_d      = hit_stolen;
                item_d       = sat_inc(item_cnt, 1'b1);
                disc_d       = sat_inc(disc_cnt, hit_disc);
                stolen_d     = sat_inc(stolen_cnt, hit_stolen);
            end
            ALARM:   alarm_d = ~clear_alarm;
            default: alarm_d = 1'b0;
        endcase
        // Counter clear wins over a same-edge increment; results still go out.
        if (clear_counts) begin
            item_d   = '0;
            disc_d   = '0;
            stolen_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q         <= '0;
            mark_q         <= 1'b0;
            res_valid      <= 1'b0;
            res_discounted <= 1'b0;
            res_stolen     <= 1'b0;
            alarm          <= 1'b0;
            item_cnt       <= '0;
            disc_cnt       <= '0;
            stolen_cnt     <= '0;
        end else begin
            if (state == IDLE && scan_valid) begin
                code_q <= scan_code;
                mark_q <= scan_mark;
            end
            res_valid      <= res_valid_d;
            res_discounted <= res_disc_d;
            res_stolen     <= res_stolen_d;
            alarm          <= alarm_d;
            item_cnt       <= item_d;
            disc_cnt       <= disc_d;
            stolen_cnt     <= stolen_d;
        end
    end

endmodule

// File: tb/tb_upc_checkout_scanner.sv
// tb/tb_upc_checkout_scanner.sv - self-checking bench for upc_checkout_scanner
module tb_upc_checkout_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       scan_valid = 1'b0, scan_ready, scan_mark = 1'b0;
    logic [2:0] scan_code = 3'd0;
    logic       clear_alarm = 1'b0, clear_counts = 1'b0;
    logic       res_valid, res_discounted, res_stolen, alarm;
    logic [3:0] item_cnt, disc_cnt, stolen_cnt;

    logic       b_valid = 1'b0, b_ready, b_mark = 1'b0;
    logic [2:0] b_code = 3'd0;
    logic       b_clear_alarm = 1'b0, b_clear_counts = 1'b0;
    logic       b_res_valid, b_res_disc, b_res_stolen, b_alarm;
    logic [3:0] b_item, b_disc, b_stolen;

    int checks = 0;
    int passed = 0;
    int m_item = 0, m_disc = 0, m_stolen = 0;

    always #5 clk = ~clk;

    upc_checkout_scanner dut (
        .clk(clk), .reset_n(reset_n),
        .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_code(scan_code), .scan_mark(scan_mark),
        .clear_alarm(clear_alarm), .clear_counts(clear_counts),
        .res_valid(res_valid), .res_discounted(res_discounted), .res_stolen(res_stolen),
        .alarm(alarm), .item_cnt(item_cnt), .disc_cnt(disc_cnt), .stolen_cnt(stolen_cnt)
    );

    upc_checkout_scanner #(.ALARM_LATCH(1'b0)) dut_pulse (
        .clk(clk), .reset_n(reset_n),
        .scan_valid(b_valid), .scan_ready(b_ready),
        .scan_code(b_code), .scan_mark(b_mark),
        .clear_alarm(b_clear_alarm), .clear_counts(b_clear_counts),
        .res_valid(b_res_valid), .res_discounted(b_res_disc), .res_stolen(b_res_stolen),
        .alarm(b_alarm), .item_cnt(b_item), .disc_cnt(b_disc), .stolen_cnt(b_stolen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Classic UPC rules, code bits {U,P,C}
    function automatic bit ref_disc(input logic [2:0] c);
        bit u = c[2], p = c[1], cc = c[0];
        return p | (u & cc);
    endfunction

    function automatic bit ref_stolen(input logic [2:0] c, input logic m);
        bit u = c[2], p = c[1], cc = c[0];
        return !m && ((!p && !cc) || (u && !p));
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_scan(input logic [2:0] c, input logic m, input logic cc);
        if (cc) begin
            m_item = 0; m_disc = 0; m_stolen = 0;
        end else begin
            m_item   = sat(m_item + 1);
            m_disc   = sat(m_disc + int'(ref_disc(c)));
            m_stolen = sat(m_stolen + int'(ref_stolen(c, m)));
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_item"}, 32'(item_cnt), m_item);
        chk({tag, "_disc"}, 32'(disc_cnt), m_disc);
        chk({tag, "_stolen"}, 32'(stolen_cnt), m_stolen);
    endtask

    // Presents one scan, optionally raising clear_counts on the evaluation edge,
    // and checks the result cycle against the reference model.
    task automatic scan_a(input string tag, input logic [2:0] c, input logic m, input logic cc);
        int n = 0;
        scan_code = c; scan_mark = m; scan_valid = 1'b1;
        while (!scan_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk({tag, "_ready_timeout"}, 32'(scan_ready), 1);
        @(posedge clk); #1;
        scan_valid = 1'b0;
        clear_counts = cc;
        @(posedge clk); #1;
        clear_counts = 1'b0;
        model_scan(c, m, cc);
        chk({tag, "_res_valid"}, 32'(res_valid), 1);
        chk({tag, "_res_disc"}, 32'(res_discounted), 32'(ref_disc(c)));
        chk({tag, "_res_stolen"}, 32'(res_stolen), 32'(ref_stolen(c, m)));
        chk({tag, "_alarm"}, 32'(alarm), 32'(ref_stolen(c, m)));
        chk_counts(tag);
    endtask

    task automatic pulse_clear_counts();
        @(posedge clk); #1;
        clear_counts = 1'b1;
        @(posedge clk); #1;
        clear_counts = 1'b0;
        m_item = 0; m_disc = 0; m_stolen = 0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 32'(scan_ready), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_item", 32'(item_cnt), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 32'(scan_ready), 1);
        chk_counts("rel");

        // First scan: code 010 unmarked is discounted, not stolen
        scan_a("first", 3'b010, 1'b0, 1'b0);

        // Exhaustive sweep with clear_alarm held, counters cleared first
        pulse_clear_counts();
        clear_alarm = 1'b1;
        for (int i = 0; i < 16; i++) begin
            scan_a($sformatf("sweep%0d", i), 3'(i >> 1), 1'(i & 1), 1'b0);
        end
        chk("sweep_item_final", 32'(item_cnt), 15);
        chk("sweep_disc_final", 32'(disc_cnt), 10);
        chk("sweep_stolen_final", 32'(stolen_cnt), 3);

        // Theft latch: alarm holds and stalls a pending scan until cleared
        clear_alarm = 1'b0;
        scan_a("theft", 3'b100, 1'b0, 1'b0);
        scan_code = 3'b010; scan_mark = 1'b1; scan_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_alarm", i), 32'(alarm), 1);
            chk($sformatf("stall%0d_ready", i), 32'(scan_ready), 0);
            chk($sformatf("stall%0d_res_valid", i), 32'(res_valid), 0);
        end
        chk_counts("stall");
        clear_alarm = 1'b1;
        @(posedge clk); #1;
        clear_alarm = 1'b0;
        chk("clr_alarm", 32'(alarm), 0);
        chk("clr_ready", 32'(scan_ready), 1);
        @(posedge clk); #1;
        scan_valid = 1'b0;
        chk("held_accepted", 32'(scan_ready), 0);
        @(posedge clk); #1;
        model_scan(3'b010, 1'b1, 1'b0);
        chk("held_res_valid", 32'(res_valid), 1);
        chk("held_res_disc", 32'(res_discounted), 1);
        chk("held_res_stolen", 32'(res_stolen), 0);
        chk_counts("held");

        // Pulse-mode build: alarm lasts exactly the result cycle
        b_code = 3'b000; b_mark = 1'b0; b_valid = 1'b1;
        chk("pulse_ready_pre", 32'(b_ready), 1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        chk("pulse_res_valid", 32'(b_res_valid), 1);
        chk("pulse_alarm_on", 32'(b_alarm), 1);
        chk("pulse_ready", 32'(b_ready), 1);
        @(posedge clk); #1;
        chk("pulse_alarm_off", 32'(b_alarm), 0);
        chk("pulse_res_valid_off", 32'(b_res_valid), 0);
        chk("pulse_stolen_cnt", 32'(b_stolen), 1);

        // Saturation and clear priority
        clear_alarm = 1'b1;
        pulse_clear_counts();
        for (int i = 0; i < 20; i++) begin
            scan_a($sformatf("sat%0d", i), 3'b111, 1'b0, 1'b0);
        end
        chk("sat_item", 32'(item_cnt), 15);
        chk("sat_disc", 32'(disc_cnt), 15);
        scan_a("sat_clear", 3'b111, 1'b0, 1'b1);

        // Randomized scans against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [2:0] rc;
            logic       rm, rcc;
            rc  = 3'($urandom_range(0, 7));
            rm  = 1'($urandom_range(0, 1));
            rcc = ($urandom_range(0, 7) == 0);
            scan_a($sformatf("rnd%0d", i), rc, rm, rcc);
        end

        // Asynchronous reset while alarmed
        clear_alarm = 1'b0;
        scan_a("pre_reset", 3'b000, 1'b0, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_alarm", 32'(alarm), 0);
        chk("async_res_valid", 32'(res_valid), 0);
        chk("async_item", 32'(item_cnt), 0);
        chk("async_disc", 32'(disc_cnt), 0);
        chk("async_stolen", 32'(stolen_cnt), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("post_reset_ready", 32'(scan_ready), 1);
        chk("post_reset_alarm", 32'(alarm), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
